// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types used by the cache blocks.
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ITAG_W = 26;
  localparam int IIDX_W = 4;
  localparam int IBYT_W = 2;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [IBYT_W-1:0] bytoff;
  } icachef_t;

endpackage

`default_nettype wire

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-frame instruction cache with a
// blocking single-word refill from memory.
`default_nettype none

module icache
  import cpu_types_pkg::*;
#(
  parameter int NFRAMES = 16,
  parameter int IDXW    = 4
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload
);

  localparam int TAGW = 30 - IDXW;

  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    word_t           data;
  } frame_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t          state;
  state_t          next_state;
  frame_t          frames [NFRAMES];
  word_t           miss_addr;
  logic [TAGW-1:0] req_tag;
  logic [IDXW-1:0] req_idx;
  logic [TAGW-1:0] miss_tag;
  logic [IDXW-1:0] miss_idx;
  logic            lookup_hit;
  logic            fill;

  assign req_tag    = imemaddr[31:IDXW+2];
  assign req_idx    = imemaddr[IDXW+1:2];
  assign miss_tag   = miss_addr[31:IDXW+2];
  assign miss_idx   = miss_addr[IDXW+1:2];
  assign lookup_hit = frames[req_idx].valid && (frames[req_idx].tag == req_tag);
  assign fill       = (state == FETCH) && !iwait;

  // The refill always targets the latched miss address, so datapath
  // address changes during FETCH cannot redirect or abort it.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
      for (int i = 0; i < NFRAMES; i++) begin
        frames[i] <= '0;
      end
    end else begin
      state <= next_state;
      if ((state == IDLE) && imemREN && !lookup_hit) begin
        miss_addr <= imemaddr & 32'hFFFF_FFFC;
      end
      if (fill) begin
        frames[miss_idx] <= '{valid: 1'b1, tag: miss_tag, data: iload};
      end
    end
  end

  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    case (state)
      IDLE: begin
        if (imemREN) begin
          if (lookup_hit) begin
            ihit     = 1'b1;
            imemload = frames[req_idx].data;
          end else begin
            next_state = FETCH;
          end
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
        if (!iwait) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// tb_icache: scoreboard-driven self-checking bench for the icache.
`timescale 1ns/1ps
`default_nettype none

module tb_icache;
  import cpu_types_pkg::*;

  logic  CLK;
  logic  nRST;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  int    errors = 0;
  int    checks = 0;
  word_t exp_q[$];

  icache #(.NFRAMES(16), .IDXW(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Backing-store contents as seen by the cache; word 0 holds the cold-miss word.
  function automatic word_t mem_word(input word_t a);
    word_t w;
    w = a & 32'hFFFF_FFFC;
    if (w == 32'h0) return 32'h2401000A;
    return (w * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  // Checks the word delivered on a hit against the scoreboard head.
  task automatic check_hit(input string name);
    word_t exp;
    checks++;
    if (ihit !== 1'b1) begin
      errors++;
      $display("FAIL %s ihit: got %b want 1", name, ihit);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: empty, got data %h", name, imemload);
    end else begin
      exp = exp_q.pop_front();
      if (imemload !== exp) begin
        errors++;
        $display("FAIL %s imemload: got %h want %h", name, imemload, exp);
      end
    end
    checks++;
    if (iREN !== 1'b0) begin
      errors++;
      $display("FAIL %s iREN on hit: got %b want 0", name, iREN);
    end
  endtask

  // One datapath fetch. On a miss, memory answers after `waits` busy cycles.
  task automatic fetch(input string name, input word_t addr, input bit miss, input int waits);
    word_t al;
    al = addr & 32'hFFFF_FFFC;
    exp_q.push_back(mem_word(addr));
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b1;
    iload    = 32'hDEAD_BEEF;
    #1;
    if (miss) begin
      checks++;
      if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0) begin
        errors++;
        $display("FAIL %s miss-detect: ihit=%b imemload=%h iREN=%b want 0/0/0",
                 name, ihit, imemload, iREN);
      end
      for (int k = 0; k <= waits; k++) begin
        @(negedge CLK);
        iwait = (k < waits);
        iload = (k < waits) ? 32'hDEAD_BEEF : mem_word(al);
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== al || ihit !== 1'b0) begin
          errors++;
          $display("FAIL %s fetch[%0d]: iREN=%b iaddr=%h ihit=%b want 1/%h/0",
                   name, k, iREN, iaddr, ihit, al);
        end
      end
      @(negedge CLK);
      iwait = 1'b1;
      iload = 32'hDEAD_BEEF;
      #1;
    end
    check_hit(name);
    @(negedge CLK);
    imemREN = 1'b0;
  endtask

  task automatic test_reset();
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = '0;
    iwait    = 1'b1;
    iload    = '0;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0 || iaddr !== 32'h0) begin
      errors++;
      $display("FAIL reset outputs: ihit=%b imemload=%h iREN=%b iaddr=%h want all 0",
               ihit, imemload, iREN, iaddr);
    end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_cold_miss();
    fetch("cold_miss", 32'h0000_0000, 1'b1, 2);
  endtask

  task automatic test_repeat_hit();
    fetch("repeat_hit", 32'h0000_0000, 1'b0, 0);
  endtask

  task automatic test_unaligned();
    fetch("unaligned_hit", 32'h0000_0003, 1'b0, 0);
  endtask

  task automatic test_conflict();
    fetch("conflict_b", 32'h0000_0040, 1'b1, 1);
    fetch("conflict_a", 32'h0000_0000, 1'b1, 0);
    fetch("conflict_rehit", 32'h0000_0002, 1'b0, 0);
  endtask

  task automatic test_idle();
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      imemREN  = 1'b0;
      imemaddr = 32'h0000_0010;
      #1;
      checks++;
      if (iREN !== 1'b0 || ihit !== 1'b0 || imemload !== 32'h0 || iaddr !== 32'h0) begin
        errors++;
        $display("FAIL idle[%0d]: iREN=%b ihit=%b imemload=%h iaddr=%h want all 0",
                 c, iREN, ihit, imemload, iaddr);
      end
    end
    fetch("idle_then_miss", 32'h0000_0010, 1'b1, 0);
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0008;
    iwait    = 1'b1;
    @(negedge CLK);
    #1;
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h0000_0008) begin
      errors++;
      $display("FAIL rst_mid fetch: iREN=%b iaddr=%h want 1/00000008", iREN, iaddr);
    end
    nRST = 1'b0;
    #1;
    checks++;
    if (iREN !== 1'b0 || iaddr !== 32'h0 || ihit !== 1'b0 || imemload !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid async: iREN=%b iaddr=%h ihit=%b imemload=%h want all 0",
               iREN, iaddr, ihit, imemload);
    end
    @(negedge CLK);
    nRST    = 1'b1;
    imemREN = 1'b0;
    #1;
    checks++;
    if (iREN !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid after: iREN=%b want 0", iREN);
    end
    // Reset also wiped the earlier fills.
    fetch("rst_mid_8_miss", 32'h0000_0008, 1'b1, 1);
    fetch("rst_mid_0_miss", 32'h0000_0000, 1'b1, 0);
  endtask

  task automatic test_addr_change_in_fetch();
    exp_q.push_back(mem_word(32'h0000_0014));
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0016;
    iwait    = 1'b1;
    @(negedge CLK);
    imemREN  = 1'b0;
    imemaddr = 32'h0000_0040;
    #1;
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h0000_0014) begin
      errors++;
      $display("FAIL hold_addr: iREN=%b iaddr=%h want 1/00000014", iREN, iaddr);
    end
    @(negedge CLK);
    iwait = 1'b0;
    iload = mem_word(32'h0000_0014);
    #1;
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h0000_0014) begin
      errors++;
      $display("FAIL hold_addr2: iREN=%b iaddr=%h want 1/00000014", iREN, iaddr);
    end
    @(negedge CLK);
    iwait    = 1'b1;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0014;
    #1;
    check_hit("hold_addr_hit");
    @(negedge CLK);
    imemREN = 1'b0;
  endtask

  task automatic test_back_to_back();
    fetch("b2b_miss", 32'h0000_0024, 1'b1, 0);
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(mem_word(32'h0000_0024));
      @(negedge CLK);
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0024;
      #1;
      check_hit("b2b_hit");
    end
    @(negedge CLK);
    imemREN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_repeat_hit();
    test_unaligned();
    test_conflict();
    test_idle();
    test_reset_mid_fetch();
    test_addr_change_in_fetch();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: %0d entries want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: NFRAMES, 16, number of direct-mapped one-word frames (power of 2).
REQ-002 Parameter: IDXW, 4, index width = log2(NFRAMES).
REQ-003 Clock and reset: CLK and nRST; nRST is asynchronous, active-low.
REQ-004 CLK  input  1  clock.
REQ-005 nRST  input  1  asynchronous active-low reset.
REQ-006 imemREN  input  1  datapath fetch request.
REQ-007 imemaddr  input  32  datapath fetch byte address.
REQ-008 ihit  output  1  requested word valid this cycle.
REQ-009 imemload  output  32  instruction word returned to datapath.
REQ-010 iREN  output  1  memory-side read request.
REQ-011 iaddr  output  32  memory-side word-aligned read address.
REQ-012 iwait  input  1  memory busy; iwait=0 with iREN=1 means iload is valid.
REQ-013 iload  input  32  memory read data.

Function
REQ-014 Address split: tag=addr[31:IDXW+2], idx=addr[IDXW+1:2], byte offset addr[1:0] ignored.
REQ-015 Each frame holds valid (1 bit), tag (30-IDXW bits), data (32 bits).
REQ-016 FSM states: IDLE, FETCH.
REQ-017 Hit is combinational, IDLE only: imemREN & valid[idx] & tag match -> ihit=1, imemload=data[idx], same cycle.
REQ-018 When ihit=0, imemload SHALL be 32'h0.
REQ-019 IDLE, imemREN=1, miss -> latch {imemaddr[31:2],2'b00} into miss-address register; next state FETCH.
REQ-020 IDLE, imemREN=0 -> stay IDLE; no memory request; ihit=0.
REQ-021 FETCH: iREN=1, iaddr=latched miss address; ihit=0 throughout.
REQ-022 FETCH, iwait=1 -> stay FETCH, address held.
REQ-023 FETCH, iwait=0 -> write frame[latched idx] = {valid=1, latched tag, iload}; next state IDLE.
REQ-024 Hit on the refilled word occurs in the first IDLE cycle after refill (miss latency = memory latency + 2 cycles from request).
REQ-025 imemREN falling or imemaddr changing during FETCH SHALL NOT abort the fill; refill completes with latched address.
REQ-026 IDLE outputs: iREN=0, iaddr=32'h0.
REQ-027 Conflict: a fill overwrites the existing frame at that index unconditionally (no replacement choice).
REQ-028 Frames are read-only to datapath; no write path, no invalidate other than reset.

Reset
REQ-029 nRST low: state=IDLE, all valid bits=0, miss-address register=0, tags/data=0.
REQ-030 During/after reset: ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-031 Reset asserted mid-FETCH abandons the fill; no frame becomes valid.

Structure
REQ-032 icachef_t (tag, idx, bytoff packed struct) and word_t belong in cpu_types_pkg; frame struct is local to icache.
REQ-033 Single module, no sub-module; frame array held in flip-flops.
REQ-034 Ports grouped on the existing datapath_cache_if (cache modport) and caches_if (icache side).

Verification
REQ-035 Cold miss: imemREN=1, imemaddr=0x00000000, iload=0x2401000A, iwait=1 for 2 cycles -> iREN=1, iaddr=0x0 for 3 cycles, then ihit=1, imemload=0x2401000A one cycle later.
REQ-036 Repeat access 0x00000000 after fill -> ihit=1 same cycle, iREN stays 0.
REQ-037 Conflict: fill 0x00000000 then 0x00000040 (same idx 0, different tag) -> second is a miss; re-access 0x00000000 misses again.
REQ-038 imemREN=0, imemaddr=0x00000010 for 5 cycles -> iREN=0, ihit=0, no state change.
REQ-039 Fill started at 0x00000008, nRST pulsed low while iwait=1 -> after reset iREN=0; access 0x00000008 misses.
REQ-040 Unaligned fetch at 0x00000003 after filling 0x00000000 -> ihit=1, same word returned.
